// File: rtl/det_event_monitor.sv
// det_event_monitor: counts high stretches of a detector level, measures each
// stretch, and offers one {length, index} report per completed stretch through
// a one-deep valid/ready holding register. Lost reports set a sticky drop flag.
// Optional feature macro: DET_MON_MAXLEN_EN adds a registered max_len output
// tracking the longest completed run since reset/clr.
module det_event_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det,
  input  logic             clr,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [LEN_W-1:0] rpt_len,
  output logic [CNT_W-1:0] rpt_idx,
  output logic [CNT_W-1:0] evt_count,
  output logic             drop
`ifdef DET_MON_MAXLEN_EN
  ,
  output logic [LEN_W-1:0] max_len
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] run_len_q;
  logic [CNT_W-1:0] cur_idx_q;
  logic [CNT_W-1:0] evt_count_q;
  logic             rpt_valid_q;
  logic [LEN_W-1:0] rpt_len_q;
  logic [CNT_W-1:0] rpt_idx_q;
  logic             drop_q;

  logic             start_c;
  logic             extend_c;
  logic             complete_c;
  logic [CNT_W-1:0] evt_inc_c;
  logic [LEN_W-1:0] len_inc_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; clr parks in FLUSH while det is still high
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = det ? FLUSH : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (det)  state_d = RUN;
        RUN:     if (!det) state_d = IDLE;
        FLUSH:   if (!det) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: strobes that drive the datapath registers
  always_comb begin
    start_c    = 1'b0;
    extend_c   = 1'b0;
    complete_c = 1'b0;
    if (!clr) begin
      case (state_q)
        IDLE:    start_c = det;
        RUN: begin
          extend_c   = det;
          complete_c = !det;
        end
        default: ;
      endcase
    end
  end

  // Saturating increments
  always_comb begin
    evt_inc_c = (evt_count_q == CNT_MAX) ? evt_count_q : evt_count_q + CNT_W'(1);
    len_inc_c = (run_len_q == LEN_MAX) ? run_len_q : run_len_q + LEN_W'(1);
  end

  // Event counter, current index and run-length measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_count_q <= '0;
      cur_idx_q   <= '0;
      run_len_q   <= '0;
    end else if (clr) begin
      evt_count_q <= '0;
      run_len_q   <= '0;
    end else if (start_c) begin
      evt_count_q <= evt_inc_c;
      cur_idx_q   <= evt_inc_c;
      run_len_q   <= LEN_W'(1);
    end else if (extend_c) begin
      run_len_q   <= len_inc_c;
    end
  end

  // One-deep report register with back-to-back handoff and sticky drop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_valid_q <= 1'b0;
      rpt_len_q   <= '0;
      rpt_idx_q   <= '0;
      drop_q      <= 1'b0;
    end else if (clr) begin
      rpt_valid_q <= 1'b0;
      drop_q      <= 1'b0;
    end else if (complete_c) begin
      if (!rpt_valid_q || rpt_ready) begin
        rpt_valid_q <= 1'b1;
        rpt_len_q   <= run_len_q;
        rpt_idx_q   <= cur_idx_q;
      end else begin
        drop_q      <= 1'b1;
      end
    end else if (rpt_valid_q && rpt_ready) begin
      rpt_valid_q <= 1'b0;
    end
  end

`ifdef DET_MON_MAXLEN_EN
  logic [LEN_W-1:0] max_len_q;

  // Longest completed run, including runs whose report was dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       max_len_q <= '0;
    else if (clr)                                    max_len_q <= '0;
    else if (complete_c && (run_len_q > max_len_q)) max_len_q <= run_len_q;
  end

  assign max_len = max_len_q;
`endif

  assign rpt_valid = rpt_valid_q;
  assign rpt_len   = rpt_len_q;
  assign rpt_idx   = rpt_idx_q;
  assign evt_count = evt_count_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_det_event_monitor.sv
// Bench for det_event_monitor: two instances (default widths and narrow
// LEN_W=3/CNT_W=2) share stimulus; a run-level model predicts both.
module tb_det_event_monitor;

  localparam int unsigned LW0 = 8;
  localparam int unsigned CW0 = 8;
  localparam int unsigned LW1 = 3;
  localparam int unsigned CW1 = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic det = 1'b0;
  logic clr = 1'b0;
  logic rpt_ready = 1'b0;

  logic           v0, d0, v1, d1;
  logic [LW0-1:0] len0;
  logic [CW0-1:0] idx0, cnt0;
  logic [LW1-1:0] len1;
  logic [CW1-1:0] idx1, cnt1;
`ifdef DET_MON_MAXLEN_EN
  logic [LW0-1:0] mx0;
  logic [LW1-1:0] mx1;
`endif

  det_event_monitor #(.CNT_W(CW0), .LEN_W(LW0)) u0 (
    .clk(clk), .reset(reset), .det(det), .clr(clr),
    .rpt_valid(v0), .rpt_ready(rpt_ready), .rpt_len(len0), .rpt_idx(idx0),
    .evt_count(cnt0), .drop(d0)
`ifdef DET_MON_MAXLEN_EN
    , .max_len(mx0)
`endif
  );

  det_event_monitor #(.CNT_W(CW1), .LEN_W(LW1)) u1 (
    .clk(clk), .reset(reset), .det(det), .clr(clr),
    .rpt_valid(v1), .rpt_ready(rpt_ready), .rpt_len(len1), .rpt_idx(idx1),
    .evt_count(cnt1), .drop(d1)
`ifdef DET_MON_MAXLEN_EN
    , .max_len(mx1)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int unsigned w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Run-level model: unbounded counts, saturation applied only when compared
  bit m_ok = 0;
  bit m_inrun, m_flush, m_valid, m_drop;
  int m_len, m_evt, m_cur, m_rlen, m_ridx, m_max;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ok = 1; m_inrun = 0; m_flush = 0; m_valid = 0; m_drop = 0;
      m_len = 0; m_evt = 0; m_cur = 0; m_rlen = 0; m_ridx = 0; m_max = 0;
    end else if (clr) begin
      m_evt = 0; m_drop = 0; m_valid = 0; m_len = 0; m_max = 0;
      m_inrun = 0; m_flush = det;
    end else begin
      if (m_inrun && !det) begin
        if (m_len > m_max) m_max = m_len;
        if (!m_valid || rpt_ready) begin
          m_valid = 1; m_rlen = m_len; m_ridx = m_cur;
        end else begin
          m_drop = 1;
        end
      end else if (m_valid && rpt_ready) begin
        m_valid = 0;
      end
      if (m_flush) begin
        if (!det) m_flush = 0;
      end else if (m_inrun) begin
        if (det) m_len++;
        else     m_inrun = 0;
      end else if (det) begin
        m_inrun = 1; m_len = 1; m_evt++; m_cur = m_evt;
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid0", 32'(v0), int'(m_valid));
      chk("drop0",  32'(d0), int'(m_drop));
      chk("count0", 32'(cnt0), sat(m_evt, CW0));
      chk("len0",   32'(len0), sat(m_rlen, LW0));
      chk("idx0",   32'(idx0), sat(m_ridx, CW0));
      chk("valid1", 32'(v1), int'(m_valid));
      chk("drop1",  32'(d1), int'(m_drop));
      chk("count1", 32'(cnt1), sat(m_evt, CW1));
      chk("len1",   32'(len1), sat(m_rlen, LW1));
      chk("idx1",   32'(idx1), sat(m_ridx, CW1));
`ifdef DET_MON_MAXLEN_EN
      chk("max0", 32'(mx0), sat(m_max, LW0));
      chk("max1", 32'(mx1), sat(m_max, LW1));
`endif
    end
  end

  // Drive inputs for one cycle; returns at the following falling edge
  task automatic cyc(input logic d, input logic r, input logic c);
    det = d; rpt_ready = r; clr = c;
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, r, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    chk("t1_count", 32'(cnt0), 0);
    chk("t1_valid", 32'(v0), 0);
    chk("t1_drop",  32'(d0), 0);

    // Single 6-cycle event, consumer always ready
    run(6, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_valid", 32'(v0), 1);
    chk("t2_len",   32'(len0), 6);
    chk("t2_idx",   32'(idx0), 1);
    chk("t2_count", 32'(cnt0), 1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t2_vclr",  32'(v0), 0);

    // Stalled consumer: second report is dropped
    cyc(1'b0, 1'b0, 1'b1);
    run(3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t3_len",  32'(len0), 3);
    chk("t3_idx",  32'(idx0), 1);
    run(2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t3_drop",  32'(d0), 1);
    chk("t3_hold",  32'(len0), 3);
    chk("t3_count", 32'(cnt0), 2);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t3_vclr",  32'(v0), 0);

    // Short runs with ready, then a true back-to-back handoff
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      run(1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("t4_idx", 32'(idx0), k);
      chk("t4_val", 32'(v0), 1);
    end
    cyc(1'b0, 1'b0, 1'b1);
    run(1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    run(1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t4_b2b_valid", 32'(v0), 1);
    chk("t4_b2b_idx",   32'(idx0), 2);
    chk("t4_b2b_drop",  32'(d0), 0);
    cyc(1'b0, 1'b1, 1'b0);

    // Saturation of length (narrow LEN_W) and count (narrow CNT_W)
    cyc(1'b0, 1'b1, 1'b1);
    run(10, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t5_len0", 32'(len0), 10);
    chk("t5_len1", 32'(len1), 7);
`ifdef DET_MON_MAXLEN_EN
    chk("t5_max0", 32'(mx0), 10);
    chk("t5_max1", 32'(mx1), 7);
`endif
    cyc(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run(1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("t5_cnt1", 32'(cnt1), 3);
    chk("t5_idx1", 32'(idx1), 3);
    chk("t5_cnt0", 32'(cnt0), 5);

    // clr mid-run: run discarded, counting restarts
    run(3, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    run(4, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_count", 32'(cnt0), 0);
    chk("t6_valid", 32'(v0), 0);
`ifdef DET_MON_MAXLEN_EN
    chk("t6_max", 32'(mx0), 0);
`endif
    run(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t6_idx", 32'(idx0), 1);
    chk("t6_len", 32'(len0), 2);
`ifdef DET_MON_MAXLEN_EN
    chk("t6_max2", 32'(mx0), 2);
`endif

    // Asynchronous reset mid-run
    run(3, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t7_count", 32'(cnt0), 0);
    chk("t7_valid", 32'(v0), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    run(2, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("t7_idx", 32'(idx0), 1);
    cyc(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
